seq_impl_checker: RTL and testbench

Synthesizable, multi-channel implication checker: per channel, when `en` is high and `ante_c && ante_d` hold at a clock edge, `cons_a==1 && cons_b==0` must hold exactly `DELAY` edges later. It is the hardware counterpart of our `(c&&d) |-> ##N (a && !b)` concurrent assertions, for on-chip monitoring and emulation where SVA is unavailable. Overlapping attempts are tracked. Results go out as pulses, saturating counters and a sticky first-failure record.

---
 rtl/seq_impl_checker.sv | 232 +++++++++++++++++++++++
 tb/tb_seq_impl_checker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_impl_checker.sv
// ---------------------------------------------------------------------------
// seq_impl_checker
//
// Multi-channel hardware implication checker, the synthesizable counterpart
// of  (c && d) |-> ##DELAY (a && !b).
//
// An attempt launches on a channel when en is high and ante_c & ante_d hold
// at a rising edge. Exactly DELAY edges later the attempt is resolved against
// cons_a (must be 1) and cons_b (must be 0). Overlapping attempts on one
// channel are tracked independently, so one attempt per channel per edge can
// be in flight at each pipeline stage.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   en             global attempt enable (gates launching only)
//   abort          synchronous flush of all pending attempts
//   clr            synchronous clear of counters and the sticky failure record
//   ante_c/ante_d  [CH] antecedent terms
//   cons_a/cons_b  [CH] consequent terms
//   pass_pulse     [CH] one-cycle pulse per passing attempt
//   fail_pulse     [CH] one-cycle pulse per failing attempt
//   pass_cnt       [CH*CNT_W] saturating pass counters, ch i at [i*CNT_W +: CNT_W]
//   fail_cnt       [CH*CNT_W] saturating fail counters, same packing
//   err            sticky: any failure since reset/clr
//   first_fail_ch  lowest failing channel on the edge err was first set
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// seq_impl_chan: one channel of the checker (pending pipeline, pulses and
// saturating counters). fail_now is the unregistered fail decision of the
// current edge, used by the top level to maintain the sticky record.
// ---------------------------------------------------------------------------
module seq_impl_chan #(
   parameter int DELAY = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             abort,
   input  logic             clr,
   input  logic             ante_c,
   input  logic             ante_d,
   input  logic             cons_a,
   input  logic             cons_b,
   output logic             pass_pulse,
   output logic             fail_pulse,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             fail_now
);

   // Shift a newly launched attempt into bit 0; the oldest attempt sits in
   // the MSB. Works for DELAY=1, where the vector is a single bit.
   function automatic logic [DELAY-1:0] shift_in(input logic [DELAY-1:0] v,
                                                 input logic             b);
      logic [DELAY-1:0] r;
      r    = v << 1'b1;
      r[0] = b;
      return r;
   endfunction

   // Increment that holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   logic [DELAY-1:0] pend_r;
   logic [DELAY-1:0] pend_nxt_s;
   logic             launch_s;
   logic             due_s;
   logic             hit_s;
   logic             pass_s;
   logic             fail_s;
   logic             pass_pulse_r;
   logic             fail_pulse_r;
   logic [CNT_W-1:0] pass_cnt_r;
   logic [CNT_W-1:0] fail_cnt_r;

   // Launch/evaluate decisions and next state of the pending pipeline.
   always_comb begin
      launch_s = en & ante_c & ante_d & ~abort;
      // abort behaves like disable-iff: the attempt reaching the end of the
      // pipeline on an abort edge is discarded, not judged.
      due_s    = pend_r[DELAY-1] & ~abort;
      hit_s    = cons_a & ~cons_b;
      pass_s   = due_s & hit_s;
      fail_s   = due_s & ~hit_s;
      if (abort) begin
         pend_nxt_s = {DELAY{1'b0}};
      end else begin
         pend_nxt_s = shift_in(pend_r, launch_s);
      end
   end

   // Pending attempts and result pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_r       <= {DELAY{1'b0}};
         pass_pulse_r <= 1'b0;
         fail_pulse_r <= 1'b0;
      end else begin
         pend_r       <= pend_nxt_s;
         // Pulses are reported even on a clr edge; only the bookkeeping
         // below drops results that coincide with clr.
         pass_pulse_r <= pass_s;
         fail_pulse_r <= fail_s;
      end
   end

   // Saturating pass/fail counters; clr wins over a same-edge result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pass_cnt_r <= {CNT_W{1'b0}};
         fail_cnt_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         pass_cnt_r <= {CNT_W{1'b0}};
         fail_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (pass_s) begin
            pass_cnt_r <= sat_inc(pass_cnt_r);
         end else begin
            pass_cnt_r <= pass_cnt_r;
         end
         if (fail_s) begin
            fail_cnt_r <= sat_inc(fail_cnt_r);
         end else begin
            fail_cnt_r <= fail_cnt_r;
         end
      end
   end

   assign pass_pulse = pass_pulse_r;
   assign fail_pulse = fail_pulse_r;
   assign pass_cnt   = pass_cnt_r;
   assign fail_cnt   = fail_cnt_r;
   assign fail_now   = fail_s;

endmodule

// ---------------------------------------------------------------------------
// seq_impl_checker: top level, CH channels plus the sticky failure record.
// ---------------------------------------------------------------------------
module seq_impl_checker #(
   parameter int CH    = 4,
   parameter int DELAY = 1,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                abort,
   input  logic                clr,
   input  logic [CH-1:0]       ante_c,
   input  logic [CH-1:0]       ante_d,
   input  logic [CH-1:0]       cons_a,
   input  logic [CH-1:0]       cons_b,
   output logic [CH-1:0]       pass_pulse,
   output logic [CH-1:0]       fail_pulse,
   output logic [CH*CNT_W-1:0] pass_cnt,
   output logic [CH*CNT_W-1:0] fail_cnt,
   output logic                err,
   output logic [4:0]          first_fail_ch
);

   // Index of the lowest set bit; 0 when none is set.
   function automatic logic [4:0] lowest_idx(input logic [CH-1:0] v);
      logic [4:0] r;
      r = 5'd0;
      for (int i = CH - 1; i >= 0; i--) begin
         if (v[i]) begin
            r = i[4:0];
         end
      end
      return r;
   endfunction

   logic [CH-1:0] fail_s;
   logic          err_r;
   logic [4:0]    first_fail_r;

   for (genvar g = 0; g < CH; g++) begin : g_ch
      seq_impl_chan #(
         .DELAY (DELAY),
         .CNT_W (CNT_W)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .en         (en),
         .abort      (abort),
         .clr        (clr),
         .ante_c     (ante_c[g]),
         .ante_d     (ante_d[g]),
         .cons_a     (cons_a[g]),
         .cons_b     (cons_b[g]),
         .pass_pulse (pass_pulse[g]),
         .fail_pulse (fail_pulse[g]),
         .pass_cnt   (pass_cnt[g*CNT_W +: CNT_W]),
         .fail_cnt   (fail_cnt[g*CNT_W +: CNT_W]),
         .fail_now   (fail_s[g])
      );
   end

   // Sticky error flag and first-failure channel; only the 0->1 transition
   // of err captures a channel, so later failures leave it untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_r        <= 1'b0;
         first_fail_r <= 5'd0;
      end else if (clr) begin
         err_r        <= 1'b0;
         first_fail_r <= 5'd0;
      end else if (!err_r && (|fail_s)) begin
         err_r        <= 1'b1;
         first_fail_r <= lowest_idx(fail_s);
      end else begin
         err_r        <= err_r;
         first_fail_r <= first_fail_r;
      end
   end

   assign err           = err_r;
   assign first_fail_ch = first_fail_r;

endmodule

// File: tb/tb_seq_impl_checker.sv
// ---------------------------------------------------------------------------
// tb_seq_impl_checker
//
// Two checker instances: A (DELAY=1, CNT_W=8) and B (DELAY=3, CNT_W=2),
// sharing clock and reset but with independent stimulus. Directed vectors
// push hand-computed expected results into per-instance queues; a monitor
// pops an entry whenever an instance raises any pulse and compares pulses,
// the named channel's counters, err and first_fail_ch.
// ---------------------------------------------------------------------------
module tb_seq_impl_checker;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance A
   logic        a_en, a_abort, a_clr;
   logic [3:0]  a_c, a_d, a_ca, a_cb;
   logic [3:0]  a_pp, a_fp;
   logic [31:0] a_pc, a_fc;
   logic        a_err;
   logic [4:0]  a_ffc;

   // instance B
   logic        b_en, b_abort, b_clr;
   logic [3:0]  b_c, b_d, b_ca, b_cb;
   logic [3:0]  b_pp, b_fp;
   logic [7:0]  b_pc, b_fc;
   logic        b_err;
   logic [4:0]  b_ffc;

   seq_impl_checker #(.CH(4), .DELAY(1), .CNT_W(8)) u_a (
      .clk(clk), .rst(rst), .en(a_en), .abort(a_abort), .clr(a_clr),
      .ante_c(a_c), .ante_d(a_d), .cons_a(a_ca), .cons_b(a_cb),
      .pass_pulse(a_pp), .fail_pulse(a_fp), .pass_cnt(a_pc), .fail_cnt(a_fc),
      .err(a_err), .first_fail_ch(a_ffc)
   );

   seq_impl_checker #(.CH(4), .DELAY(3), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst), .en(b_en), .abort(b_abort), .clr(b_clr),
      .ante_c(b_c), .ante_d(b_d), .cons_a(b_ca), .cons_b(b_cb),
      .pass_pulse(b_pp), .fail_pulse(b_fp), .pass_cnt(b_pc), .fail_cnt(b_fc),
      .err(b_err), .first_fail_ch(b_ffc)
   );

   typedef struct {
      logic [3:0] pp;
      logic [3:0] fp;
      int         ch;
      int         pcnt;
      int         fcnt;
      logic       err;
      logic [4:0] ffc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] pp, input logic [3:0] fp, input int ch,
                               input int pc, input int fc, input logic er, input logic [4:0] ff);
      exp_t e;
      e.pp = pp; e.fp = fp; e.ch = ch; e.pcnt = pc; e.fcnt = fc; e.err = er; e.ffc = ff;
      return e;
   endfunction

   // Monitor: any pulse must match the next expected entry of its instance.
   always @(negedge clk) begin
      if (a_pp != 4'd0 || a_fp != 4'd0) begin
         if (qa.size() == 0) begin
            chk("A unexpected pulse", {24'd0, a_pp, a_fp}, 32'd0);
         end else begin
            ea = qa.pop_front();
            chk("A pass_pulse", {28'd0, a_pp}, {28'd0, ea.pp});
            chk("A fail_pulse", {28'd0, a_fp}, {28'd0, ea.fp});
            chk("A pass_cnt",   {24'd0, a_pc[ea.ch*8 +: 8]}, ea.pcnt);
            chk("A fail_cnt",   {24'd0, a_fc[ea.ch*8 +: 8]}, ea.fcnt);
            chk("A err",        {31'd0, a_err}, {31'd0, ea.err});
            chk("A first_fail_ch", {27'd0, a_ffc}, {27'd0, ea.ffc});
         end
      end
      if (b_pp != 4'd0 || b_fp != 4'd0) begin
         if (qb.size() == 0) begin
            chk("B unexpected pulse", {24'd0, b_pp, b_fp}, 32'd0);
         end else begin
            eb = qb.pop_front();
            chk("B pass_pulse", {28'd0, b_pp}, {28'd0, eb.pp});
            chk("B fail_pulse", {28'd0, b_fp}, {28'd0, eb.fp});
            chk("B pass_cnt",   {30'd0, b_pc[eb.ch*2 +: 2]}, eb.pcnt);
            chk("B fail_cnt",   {30'd0, b_fc[eb.ch*2 +: 2]}, eb.fcnt);
            chk("B err",        {31'd0, b_err}, {31'd0, eb.err});
            chk("B first_fail_ch", {27'd0, b_ffc}, {27'd0, eb.ffc});
         end
      end
   end

   task automatic clear_a();
      a_en = 1'b1; a_abort = 1'b0; a_clr = 1'b0;
      a_c = 4'd0; a_d = 4'd0; a_ca = 4'd0; a_cb = 4'd0;
   endtask

   task automatic clear_b();
      b_en = 1'b1; b_abort = 1'b0; b_clr = 1'b0;
      b_c = 4'd0; b_d = 4'd0; b_ca = 4'd0; b_cb = 4'd0;
   endtask

   // One rising edge; returns at the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " A pulses"}, {24'd0, a_pp, a_fp}, 32'd0);
      chk({tag, " A pass_cnt"}, a_pc, 32'd0);
      chk({tag, " A fail_cnt"}, a_fc, 32'd0);
      chk({tag, " A err/ffc"}, {26'd0, a_err, a_ffc}, 32'd0);
      chk({tag, " B pulses"}, {24'd0, b_pp, b_fp}, 32'd0);
      chk({tag, " B counters"}, {16'd0, b_pc, b_fc}, 32'd0);
      chk({tag, " B err/ffc"}, {26'd0, b_err, b_ffc}, 32'd0);
   endtask

   int sat_exp[6] = '{1, 2, 3, 3, 3, 0};

   initial begin
      rst = 1'b0;
      clear_a();
      clear_b();
      step();
      step();
      chk_all_zero("reset");
      rst = 1'b1;
      step();

      // ---------------- instance A, DELAY=1 ----------------
      // ch0 pass
      clear_a(); a_c = 4'b0001; a_d = 4'b0001; step();
      clear_a(); a_ca = 4'b0001; qa.push_back(mk(4'b0001, 4'b0000, 0, 1, 0, 1'b0, 5'd0)); step();
      clear_a(); step();
      // ch2 with only d high: no attempt, so b=1 later causes nothing
      clear_a(); a_d = 4'b0100; step();
      clear_a(); a_cb = 4'b0100; step();
      // ch2 attempt, consequent a=1,b=1 fails
      clear_a(); a_c = 4'b0100; a_d = 4'b0100; step();
      clear_a(); a_ca = 4'b0100; a_cb = 4'b0100;
      qa.push_back(mk(4'b0000, 4'b0100, 2, 0, 1, 1'b1, 5'd2)); step();
      // later fail on ch1 leaves first_fail_ch at 2
      clear_a(); a_c = 4'b0010; a_d = 4'b0010; step();
      clear_a(); qa.push_back(mk(4'b0000, 4'b0010, 1, 0, 1, 1'b1, 5'd2)); step();
      // clr
      clear_a(); a_clr = 1'b1; step();
      chk("A clr err", {31'd0, a_err}, 32'd0);
      chk("A clr first_fail_ch", {27'd0, a_ffc}, 32'd0);
      chk("A clr counters", a_pc | a_fc, 32'd0);
      // simultaneous fails on ch1 and ch3: lowest index captured
      clear_a(); a_c = 4'b1010; a_d = 4'b1010; step();
      clear_a(); qa.push_back(mk(4'b0000, 4'b1010, 3, 0, 1, 1'b1, 5'd1)); step();
      // back-to-back passes on ch0
      clear_a(); a_c = 4'b0001; a_d = 4'b0001; step();
      clear_a(); a_c = 4'b0001; a_d = 4'b0001; a_ca = 4'b0001;
      qa.push_back(mk(4'b0001, 4'b0000, 0, 1, 0, 1'b1, 5'd1)); step();
      clear_a(); a_ca = 4'b0001; qa.push_back(mk(4'b0001, 4'b0000, 0, 2, 0, 1'b1, 5'd1)); step();
      clear_a(); step();
      // abort on the evaluation edge: no result, and its own launch is suppressed
      clear_a(); a_c = 4'b0001; a_d = 4'b0001; step();
      clear_a(); a_abort = 1'b1; a_ca = 4'b0001; a_c = 4'b0001; a_d = 4'b0001; step();
      clear_a(); a_ca = 4'b0001; step();
      clear_a(); step();
      chk("A abort pass_cnt ch0", {24'd0, a_pc[7:0]}, 32'd2);

      // ---------------- instance B, DELAY=3, CNT_W=2 ----------------
      // ch1 four consecutive attempts: pass, fail, pass, pass
      clear_b(); b_c = 4'b0010; b_d = 4'b0010; step();
      clear_b(); b_c = 4'b0010; b_d = 4'b0010; step();
      clear_b(); b_c = 4'b0010; b_d = 4'b0010; step();
      clear_b(); b_c = 4'b0010; b_d = 4'b0010; b_ca = 4'b0010;
      qb.push_back(mk(4'b0010, 4'b0000, 1, 1, 0, 1'b0, 5'd0)); step();
      clear_b(); qb.push_back(mk(4'b0000, 4'b0010, 1, 1, 1, 1'b1, 5'd1)); step();
      clear_b(); b_ca = 4'b0010; qb.push_back(mk(4'b0010, 4'b0000, 1, 2, 1, 1'b1, 5'd1)); step();
      clear_b(); b_ca = 4'b0010; qb.push_back(mk(4'b0010, 4'b0000, 1, 3, 1, 1'b1, 5'd1)); step();
      clear_b(); b_clr = 1'b1; step();
      chk("B clr err", {31'd0, b_err}, 32'd0);
      chk("B clr counters", {16'd0, b_pc, b_fc}, 32'd0);
      // ch0 attempt flushed by abort two edges later
      clear_b(); b_c = 4'b0001; b_d = 4'b0001; step();
      clear_b(); step();
      clear_b(); b_abort = 1'b1; b_c = 4'b0001; b_d = 4'b0001; step();
      clear_b(); b_ca = 4'b0001; step();
      clear_b(); b_ca = 4'b0001; step();
      clear_b(); b_ca = 4'b0001; step();
      clear_b(); step();
      chk("B abort counters ch0", {30'd0, b_pc[1:0]}, 32'd0);
      // en low for one edge does not cancel an earlier attempt on ch2
      clear_b(); b_c = 4'b0100; b_d = 4'b0100; step();
      clear_b(); b_en = 1'b0; b_c = 4'b0100; b_d = 4'b0100; step();
      clear_b(); step();
      clear_b(); b_ca = 4'b0100; qb.push_back(mk(4'b0100, 4'b0000, 2, 1, 0, 1'b0, 5'd0)); step();
      clear_b(); b_ca = 4'b0100; step();
      clear_b(); step();
      // ch3 saturation then clr coincident with a pass
      for (int k = 1; k <= 9; k++) begin
         clear_b();
         if (k <= 6) begin
            b_c = 4'b1000; b_d = 4'b1000;
         end
         if (k >= 4) begin
            b_ca = 4'b1000;
            qb.push_back(mk(4'b1000, 4'b0000, 3, sat_exp[k-4], 0, 1'b0, 5'd0));
         end
         if (k == 9) begin
            b_clr = 1'b1;
         end
         step();
      end
      clear_b(); step();
      step();

      // ---------------- reset between launch and evaluation ----------------
      clear_a(); clear_b(); a_c = 4'b0001; a_d = 4'b0001; b_c = 4'b0001; b_d = 4'b0001; step();
      clear_a(); clear_b(); a_ca = 4'b0001; b_ca = 4'b0001;
      #1 rst = 1'b0;
      #1 chk_all_zero("async reset");
      #1 rst = 1'b1;
      step();
      clear_a(); step();
      step();
      clear_b(); step();
      step();
      chk_all_zero("after reset");

      chk("A queue drained", qa.size(), 32'd0);
      chk("B queue drained", qb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
